soc_bus_decoder: RTL and testbench
==================================

// Module: soc_bus_decoder
// PURPOSE
//  Address decoder and bridge between the CPU native memory port (valid/ready/addr/wdata/wstrb/rdata)
//  and the downstream 4 KB on-chip RAM. Routes RAM-window accesses to the RAM port. Serves a small
//  MMIO bank locally: LED register, free-running cycle counter, status/error register.
//  Flags unmapped addresses and RAM timeouts.
// PARAMETERS
//  RAM_AW     10            RAM word-address width (2**RAM_AW words; 10 -> 4 KB)
//  MMIO_BASE  32'h1000_0000 base of MMIO window (16 bytes, 3 words used)
//  LED_W      8             width of LED register / leds output
//  TIMEOUT    16            max cycles in RAM_WAIT before abort (>=2)
// PORTS
//  clk        in   1        system clock, all logic rising-edge
//  resetn     in   1        asynchronous active-low reset
//  cpu_valid  in   1        CPU request valid, held until cpu_ready
//  cpu_ready  out  1        one-cycle response strobe to CPU
//  cpu_addr   in   32       byte address
//  cpu_wdata  in   32       write data
//  cpu_wstrb  in   4        byte write enables; 4'b0000 = read
//  cpu_rdata  out  32       read data, valid while cpu_ready=1
//  ram_valid  out  1        request to RAM, registered
//  ram_ready  in   1        RAM response (RAM asserts it one cycle after sampling valid)
//  ram_addr   out  RAM_AW   RAM word address = cpu_addr[RAM_AW+1:2]
//  ram_wdata  out  32       registered copy of cpu_wdata
//  ram_wstrb  out  4        registered copy of cpu_wstrb
//  ram_rdata  in   32       RAM read data, valid with ram_ready
//  leds       out  LED_W    LED register contents
//  bus_err    out  1        sticky error flag
// BEHAVIOUR
//  Reset (async, resetn=0): state IDLE; cpu_ready=0, cpu_rdata=0, ram_valid=0, ram_addr/wdata/wstrb=0,
//   leds=0, bus_err=0, err_count=0, cycle counter=0. Reset mid-transaction aborts it; no response issued.
//  Decode, sampled only in IDLE: RAM if cpu_addr < 4*2**RAM_AW; MMIO if cpu_addr[31:4]==MMIO_BASE[31:4];
//   otherwise unmapped. addr[1:0] ignored.
//  FSM, states IDLE, RAM_WAIT, RESP:
//   IDLE: cpu_valid=1 & RAM -> latch addr/wdata/wstrb onto ram_* ports, ram_valid<=1, tmo<=0, go RAM_WAIT.
//         cpu_valid=1 & MMIO -> perform access this edge, latch cpu_rdata, go RESP.
//         cpu_valid=1 & unmapped -> cpu_rdata<=0, bus_err<=1, err_count++, go RESP.
//   RAM_WAIT: ram_ready=1 -> cpu_rdata<=ram_rdata (0 for writes), ram_valid<=0, go RESP.
//         else tmo++; tmo==TIMEOUT-1 -> ram_valid<=0, cpu_rdata<=32'hFFFF_FFFF, bus_err<=1,
//         err_count++, go RESP.
//   RESP: cpu_ready=1 for exactly this one cycle; unconditionally go IDLE.
//  cpu_ready is a Moore output of RESP. ram_ready is sampled only in RAM_WAIT, so the extra ready the RAM
//   emits after ram_valid falls lands in RESP and is ignored. cpu_valid is ignored in RESP.
//  Latency, counted from the IDLE edge that accepts cpu_valid: MMIO and unmapped cpu_ready after 1 cycle;
//   RAM cpu_ready after 3 cycles with a 1-cycle RAM. Back-to-back requests are accepted the edge after RESP.
//  MMIO map, offsets from MMIO_BASE:
//   0x0 LED: RW; byte lanes per wstrb apply to bits < LED_W; read zero-extended.
//   0x4 CYCLE: RO 32-bit counter, +1 every clock, wraps 0xFFFF_FFFF->0. Writes ignored, no error.
//   0x8 STATUS: read {16'b0, err_count[7:0], 7'b0, bus_err}. err_count saturates at 255.
//       A write with wstrb[0]=1 and wdata[0]=1 clears bus_err and err_count.
//   0xC: reads 0, writes ignored, no error.
//  Simultaneous events: if an error increment and a STATUS clear fall on the same edge, the clear wins.
//  A late ram_ready after a timeout is not supported; the RAM must be quiescent once ram_valid falls.
// TESTING
//  1. Reset, write 0x0000_0004 data 0xCAFEBABE wstrb 4'hF, then read it back -> ram_addr=1,
//     cpu_ready 3 cycles after accept, cpu_rdata=0xCAFEBABE, exactly one cpu_ready pulse per access.
//  2. Write LED (0x1000_0000) data 0x0000_00A5 wstrb 4'h1 -> leds=0xA5 after 1 cycle, ram_valid stays 0;
//     write with wstrb 4'h2 leaves leds unchanged (LED_W=8).
//  3. Read CYCLE twice 10 cycles apart -> difference 10 plus access spacing. Force the counter to
//     0xFFFF_FFFF -> next value 0.
//  4. Read 0x2000_0000 -> cpu_rdata=0, bus_err=1, STATUS=0x0000_0101. Write STATUS 0x1 wstrb 4'h1 ->
//     STATUS reads 0, bus_err=0.
//  5. RAM model never asserts ram_ready -> ram_valid drops and cpu_ready pulses with rdata 0xFFFF_FFFF
//     16 cycles after accept; bus_err=1.
//  6. Assert resetn=0 while in RAM_WAIT -> ram_valid=0 immediately, no cpu_ready. The next read after
//     release completes normally.

Source files
------------

// File: rtl/soc_bus_decoder.sv
// soc_bus_decoder: CPU native-port decoder/bridge to 4 KB RAM plus local MMIO bank
// (LED, free-running cycle counter, status/error register).
//
// Ports:
//   clk, resetn                 clock, async active-low reset
//   cpu_valid/ready/addr/wdata/wstrb/rdata   CPU native memory port (ready is a 1-cycle strobe)
//   ram_valid/ready/addr/wdata/wstrb/rdata   downstream RAM port (request side registered)
//   leds                        LED register contents
//   bus_err                     sticky error flag (unmapped access or RAM timeout)
module soc_bus_decoder #(
    parameter int unsigned RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int unsigned LED_W     = 8,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic [31:0]       cpu_rdata,
    output logic              ram_valid,
    input  logic              ram_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wstrb,
    input  logic [31:0]       ram_rdata,
    output logic [LED_W-1:0]  leds,
    output logic              bus_err
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Abort once the incremented wait count reaches TIMEOUT-1.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_WAIT = 2'd1,
        RESP     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              ram_valid_q, ram_valid_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [3:0]        ram_wstrb_q, ram_wstrb_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              bus_err_q, bus_err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic        is_ram;
    logic        is_mmio;
    logic [31:0] mmio_rdata;
    logic [31:0] lane_mask;
    logic        err_inc;
    logic        err_clr;

    assign is_ram  = (cpu_addr[31:RAM_AW+2] == '0);
    assign is_mmio = (cpu_addr[31:4] == MMIO_BASE[31:4]);

    assign lane_mask = {{8{cpu_wstrb[3]}}, {8{cpu_wstrb[2]}},
                        {8{cpu_wstrb[1]}}, {8{cpu_wstrb[0]}}};

    always_comb begin
        mmio_rdata = 32'h0;
        unique case (cpu_addr[3:2])
            2'd0:    mmio_rdata = 32'(led_q);
            2'd1:    mmio_rdata = cyc_q;
            2'd2:    mmio_rdata = {16'h0, err_count_q, 7'h0, bus_err_q};
            default: mmio_rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ram_valid_d = ram_valid_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wstrb_d = ram_wstrb_q;
        led_d       = led_q;
        bus_err_d   = bus_err_q;
        err_count_d = err_count_q;
        cyc_d       = cyc_q + 32'd1;
        tmo_d       = tmo_q;
        err_inc     = 1'b0;
        err_clr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    if (is_ram) begin
                        ram_valid_d = 1'b1;
                        ram_addr_d  = cpu_addr[RAM_AW+1:2];
                        ram_wdata_d = cpu_wdata;
                        ram_wstrb_d = cpu_wstrb;
                        tmo_d       = '0;
                        state_d     = RAM_WAIT;
                    end else if (is_mmio) begin
                        cpu_rdata_d = mmio_rdata;
                        cpu_ready_d = 1'b1;
                        state_d     = RESP;
                        if (cpu_addr[3:2] == 2'd0) begin
                            led_d = (led_q & ~lane_mask[LED_W-1:0])
                                  | (cpu_wdata[LED_W-1:0] & lane_mask[LED_W-1:0]);
                        end
                        if (cpu_addr[3:2] == 2'd2 && cpu_wstrb[0] && cpu_wdata[0]) begin
                            err_clr = 1'b1;
                        end
                    end else begin
                        cpu_rdata_d = 32'h0;
                        cpu_ready_d = 1'b1;
                        err_inc     = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            RAM_WAIT: begin
                if (ram_ready) begin
                    cpu_rdata_d = (|ram_wstrb_q) ? 32'h0 : ram_rdata;
                    ram_valid_d = 1'b0;
                    cpu_ready_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TMO_LAST) begin
                        ram_valid_d = 1'b0;
                        cpu_rdata_d = 32'hFFFF_FFFF;
                        cpu_ready_d = 1'b1;
                        err_inc     = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_inc) begin
            bus_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
        // A status clear on the same edge overrides an error increment.
        if (err_clr) begin
            bus_err_d   = 1'b0;
            err_count_d = 8'h0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= 32'h0;
            ram_valid_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'h0;
            ram_wstrb_q <= 4'h0;
            led_q       <= '0;
            bus_err_q   <= 1'b0;
            err_count_q <= 8'h0;
            cyc_q       <= 32'h0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            ram_valid_q <= ram_valid_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wstrb_q <= ram_wstrb_d;
            led_q       <= led_d;
            bus_err_q   <= bus_err_d;
            err_count_q <= err_count_d;
            cyc_q       <= cyc_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ram_valid = ram_valid_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wstrb = ram_wstrb_q;
    assign leds      = led_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_soc_bus_decoder.sv
// tb_soc_bus_decoder: directed self-checking bench for soc_bus_decoder
// with a 1-cycle RAM model that can be made unresponsive.
module tb_soc_bus_decoder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cpu_valid = 1'b0;
    logic        cpu_ready;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [3:0]  cpu_wstrb = 4'h0;
    logic [31:0] cpu_rdata;
    logic        ram_valid;
    logic        ram_ready = 1'b0;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata = 32'h0;
    logic [7:0]  leds;
    logic        bus_err;

    int npass = 0;
    int ntotal = 0;
    int nfail = 0;
    int ecnt = 0;
    int acc_e = 0;
    bit ram_dead = 1'b0;

    logic [31:0] mem [0:1023];

    soc_bus_decoder dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_valid (cpu_valid),
        .cpu_ready (cpu_ready),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_rdata (cpu_rdata),
        .ram_valid (ram_valid),
        .ram_ready (ram_ready),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wstrb (ram_wstrb),
        .ram_rdata (ram_rdata),
        .leds      (leds),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt++;

    // RAM answers one cycle after sampling ram_valid.
    always @(posedge clk) begin
        ram_ready <= ram_valid & ~ram_dead;
        if (ram_valid && !ram_dead) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd,
                          output int lat, output bit sawram);
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wstrb = s;
        lat = 0;
        sawram = 1'b0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) acc_e = ecnt;
            if (ram_valid) sawram = 1'b1;
            if (cpu_ready) break;
        end
        chk("ready_seen", {31'h0, cpu_ready}, 32'h1);
        rd = cpu_rdata;
        @(negedge clk);
        cpu_valid = 1'b0;
        cpu_wstrb = 4'h0;
        @(posedge clk);
        #1;
        chk("one_pulse", {31'h0, cpu_ready}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] r1;
        int lat;
        int e1;
        bit sr;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, cpu_ready}, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_ram_valid", {31'h0, ram_valid}, 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // RAM write then read back
        access(32'h0000_0004, 32'hCAFE_BABE, 4'hF, rd, lat, sr);
        chk("ram_wr_lat", 32'(lat), 32'd3);
        chk("ram_wr_addr", 32'(ram_addr), 32'd1);
        chk("ram_wr_rdata", rd, 32'h0);
        chk("ram_wr_sawvalid", {31'h0, sr}, 32'h1);
        access(32'h0000_0004, 32'h0, 4'h0, rd, lat, sr);
        chk("ram_rd_lat", 32'(lat), 32'd3);
        chk("ram_rd_data", rd, 32'hCAFE_BABE);
        access(32'h0000_0007, 32'h0, 4'h0, rd, lat, sr);
        chk("ram_rd_lowbits", rd, 32'hCAFE_BABE);
        chk("ram_valid_idle", {31'h0, ram_valid}, 32'h0);

        // LED register
        access(32'h1000_0000, 32'h0000_00A5, 4'h1, rd, lat, sr);
        chk("led_lat", 32'(lat), 32'd1);
        chk("led_val", 32'(leds), 32'hA5);
        chk("led_no_ram", {31'h0, sr}, 32'h0);
        access(32'h1000_0000, 32'hFFFF_FFFF, 4'h2, rd, lat, sr);
        chk("led_lane1", 32'(leds), 32'hA5);
        access(32'h1000_0000, 32'h0, 4'h0, rd, lat, sr);
        chk("led_read", rd, 32'h0000_00A5);

        // Cycle counter, ignored writes, spare word
        access(32'h1000_0004, 32'h0, 4'h0, r1, lat, sr);
        e1 = acc_e;
        repeat (10) @(posedge clk);
        access(32'h1000_0004, 32'h0, 4'h0, rd, lat, sr);
        chk("cyc_edges", 32'(acc_e - e1), 32'd12);
        chk("cyc_diff", rd - r1, 32'd12);
        access(32'h1000_0004, 32'h1234_5678, 4'hF, rd, lat, sr);
        access(32'h1000_000C, 32'h1234_5678, 4'hF, rd, lat, sr);
        access(32'h1000_000C, 32'h0, 4'h0, rd, lat, sr);
        chk("spare_read", rd, 32'h0);
        chk("no_err_yet", {31'h0, bus_err}, 32'h0);
        @(negedge clk);
        force dut.cyc_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.cyc_q;
        chk("cyc_forced", dut.cyc_q, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        chk("cyc_wrap", dut.cyc_q, 32'h0);
        access(32'h1000_0004, 32'h0, 4'h0, rd, lat, sr);
        chk("cyc_wrap_read", rd, 32'h0);

        // Unmapped access and status clear
        access(32'h2000_0000, 32'h0, 4'h0, rd, lat, sr);
        chk("unmap_lat", 32'(lat), 32'd1);
        chk("unmap_rdata", rd, 32'h0);
        chk("unmap_err", {31'h0, bus_err}, 32'h1);
        access(32'h1000_0008, 32'h0, 4'h0, rd, lat, sr);
        chk("status_1", rd, 32'h0000_0101);
        access(32'h1000_0008, 32'h0000_0001, 4'h1, rd, lat, sr);
        access(32'h1000_0008, 32'h0, 4'h0, rd, lat, sr);
        chk("status_clr", rd, 32'h0);
        chk("err_clr", {31'h0, bus_err}, 32'h0);

        // RAM timeout
        ram_dead = 1'b1;
        access(32'h0000_0008, 32'h0, 4'h0, rd, lat, sr);
        chk("tmo_lat", 32'(lat), 32'd16);
        chk("tmo_rdata", rd, 32'hFFFF_FFFF);
        chk("tmo_err", {31'h0, bus_err}, 32'h1);
        chk("tmo_valid_low", {31'h0, ram_valid}, 32'h0);
        access(32'h1000_0008, 32'h0, 4'h0, rd, lat, sr);
        chk("tmo_status", rd, 32'h0000_0101);

        // Reset during RAM_WAIT
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = 32'h0000_0004;
        cpu_wstrb = 4'h0;
        @(posedge clk);
        #1;
        chk("wait_valid", {31'h0, ram_valid}, 32'h1);
        #2;
        resetn = 1'b0;
        cpu_valid = 1'b0;
        #1;
        chk("rst_async_valid", {31'h0, ram_valid}, 32'h0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (cpu_ready) seen = 1'b1;
        end
        chk("rst_no_ready", {31'h0, seen}, 32'h0);
        chk("rst_err_clr", {31'h0, bus_err}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        ram_dead = 1'b0;
        access(32'h0000_0004, 32'h0, 4'h0, rd, lat, sr);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_data", rd, 32'hCAFE_BABE);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
